// File: rtl/uart_ctrl_fifo_pkg.sv
// Shared types and helpers for the UART controller byte FIFO.
// The trigger-level decode lives here so TX and RX instances agree on thresholds.
package uart_ctrl_fifo_pkg;

  typedef enum logic [1:0] {
    TRIG_1         = 2'd0,
    TRIG_QTR       = 2'd1,
    TRIG_HALF      = 2'd2,
    TRIG_NEAR_FULL = 2'd3
  } trig_sel_e;

  function automatic int trig_level(trig_sel_e sel, int depth);
    case (sel)
      TRIG_1:    return 1;
      TRIG_QTR:  return depth / 4;
      TRIG_HALF: return depth / 2;
      default:   return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_ctrl_fifo_if.sv
// Bus between the UART controller (master) and one byte FIFO instance (slave).
interface uart_ctrl_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshake: push is accepted on a rising edge when the FIFO is not full, or when it is
  // full and pop is high on the same edge; pop is accepted when the FIFO is not empty.
  // rd_data holds the head entry whenever empty is low. clear overrides both requests.
  logic              clear;
  logic              push;
  logic [DATA_W-1:0] wr_data;
  logic              pop;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  fifo_ptr;
  logic [1:0]        trig_sel;
  logic              trig;
  logic              overrun;
  logic              underrun;
  logic              clr_err;

  modport master (
    output clear, push, wr_data, pop, trig_sel, clr_err,
    input  rd_data, empty, full, fifo_ptr, trig, overrun, underrun
  );

  modport slave (
    input  clear, push, wr_data, pop, trig_sel, clr_err,
    output rd_data, empty, full, fifo_ptr, trig, overrun, underrun
  );

endinterface

// File: rtl/uart_ctrl_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read, no reset.
module uart_ctrl_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_ctrl_fifo.sv
// UART controller byte FIFO: pointers, occupancy count, error flags and trigger compare.
// DEPTH must be a power of two and at least 4 so the pointers wrap naturally.
module uart_ctrl_fifo
  import uart_ctrl_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  uart_ctrl_fifo_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             overrun_q;
  logic             underrun_q;
  logic             empty_w;
  logic             full_w;
  logic             push_ok;
  logic             pop_ok;
  logic             overflow;

  // Flags decode only the count register, never the requests, so they cannot glitch.
  assign empty_w  = (cnt == '0);
  assign full_w   = (cnt == CNT_FULL);
  assign push_ok  = bus.push & (~full_w | bus.pop);
  assign pop_ok   = bus.pop & ~empty_w;
  assign overflow = bus.push & full_w & ~bus.pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A dropped push wins over clr_err on the same edge; clear leaves the sticky flag alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (overflow & ~bus.clear) overrun_q <= 1'b1;
      else if (bus.clr_err)      overrun_q <= 1'b0;
      underrun_q <= ~bus.clear & bus.pop & empty_w;
    end
  end

  uart_ctrl_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (push_ok & ~bus.clear),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (bus.rd_data)
  );

  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.fifo_ptr = cnt;
  assign bus.overrun  = overrun_q;
  assign bus.underrun = underrun_q;
  assign bus.trig     = int'(cnt) >= trig_level(trig_sel_e'(bus.trig_sel), DEPTH);

endmodule

// File: tb/tb_uart_ctrl_fifo.sv
// Directed bench for uart_ctrl_fifo: status checks against hand-computed values and a
// scoreboard queue of expected read data, drained by a negedge monitor on each accepted pop.
module tb_uart_ctrl_fifo;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic exp_pop;
  logic [7:0] exp_q[$];

  uart_ctrl_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

  uart_ctrl_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; returns at posedge+1 with post-edge outputs settled.
  task automatic step(input logic p, input logic [7:0] d, input logic q, input logic ep);
    bus.push    = p;
    bus.wr_data = d;
    bus.pop     = q;
    exp_pop     = ep;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    exp_pop  = 1'b0;
  endtask

  // Monitor: inputs are stable at negedge, so an expected pop compares the current head.
  always @(negedge clk) begin
    if (exp_pop === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_data: pop with no expected data, got %0h", bus.rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          miscompares++;
          $display("FAIL rd_data: got %0h, expected %0h", bus.rd_data, e);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_pop     = 1'b0;
    rst_n       = 1'b0;
    bus.clear   = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_err = 1'b0;
    bus.trig_sel = 2'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset empty", int'(bus.empty), 1);
    chk("reset full", int'(bus.full), 0);
    chk("reset fifo_ptr", int'(bus.fifo_ptr), 0);
    chk("reset trig sel0", int'(bus.trig), 0);
    chk("reset overrun", int'(bus.overrun), 0);
    chk("reset underrun", int'(bus.underrun), 0);
    bus.trig_sel = 2'd3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill 0x00..0x0F; near-full trigger at 14
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'(i));
      chk("fill fifo_ptr", int'(bus.fifo_ptr), i + 1);
      chk("fill trig", int'(bus.trig), (i + 1 >= 14) ? 1 : 0);
      if (i == 3) begin
        bus.trig_sel = 2'd1; #1;
        chk("trig qtr at 4", int'(bus.trig), 1);
        bus.trig_sel = 2'd2; #1;
        chk("trig half at 4", int'(bus.trig), 0);
        bus.trig_sel = 2'd0; #1;
        chk("trig one at 4", int'(bus.trig), 1);
        bus.trig_sel = 2'd3; #1;
      end
    end
    chk("fill full", int'(bus.full), 1);
    chk("fill empty", int'(bus.empty), 0);

    // Overflow, clr_err, and set-wins on a simultaneous overflow + clr_err
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf fifo_ptr", int'(bus.fifo_ptr), 16);
    chk("ovf overrun", int'(bus.overrun), 1);
    bus.clr_err = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_err overrun", int'(bus.overrun), 0);
    step(1'b1, 8'hAB, 1'b0, 1'b0);
    chk("ovf+clr_err overrun", int'(bus.overrun), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    bus.clr_err = 1'b0;
    chk("clr_err again overrun", int'(bus.overrun), 0);

    // Push+pop while full across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'h40 + 8'(i), 1'b1, 1'b1);
      exp_q.push_back(8'h40 + 8'(i));
      chk("stream fifo_ptr", int'(bus.fifo_ptr), 16);
    end
    chk("stream overrun", int'(bus.overrun), 0);

    // Drain
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("drain fifo_ptr", int'(bus.fifo_ptr), 15 - i);
    end
    chk("drain empty", int'(bus.empty), 1);

    // Underrun and push+pop on empty
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("underrun pulse", int'(bus.underrun), 1);
    chk("underrun fifo_ptr", int'(bus.fifo_ptr), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("underrun cleared", int'(bus.underrun), 0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    exp_q.push_back(8'h5A);
    chk("pp empty fifo_ptr", int'(bus.fifo_ptr), 1);
    chk("pp empty underrun", int'(bus.underrun), 1);
    chk("pp empty rd_data", int'(bus.rd_data), 8'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("pp empty drained", int'(bus.empty), 1);

    // Fill, overflow, pop to 9 entries, then clear with push asserted
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'h90 + 8'(i));
    end
    step(1'b1, 8'hCC, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("pre-clear fifo_ptr", int'(bus.fifo_ptr), 9);
    bus.clear = 1'b1;
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    bus.clear = 1'b0;
    exp_q.delete();
    chk("clear fifo_ptr", int'(bus.fifo_ptr), 0);
    chk("clear empty", int'(bus.empty), 1);
    chk("clear overrun kept", int'(bus.overrun), 1);
    bus.clr_err = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    bus.clr_err = 1'b0;

    // Asynchronous reset mid-burst at 7 entries
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'h60 + 8'(i));
    end
    chk("burst fifo_ptr", int'(bus.fifo_ptr), 7);
    bus.push    = 1'b1;
    bus.wr_data = 8'h67;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async rst fifo_ptr", int'(bus.fifo_ptr), 0);
    chk("async rst empty", int'(bus.empty), 1);
    chk("async rst full", int'(bus.full), 0);
    chk("async rst trig", int'(bus.trig), 0);
    exp_q.delete();
    bus.push = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    exp_q.push_back(8'h77);
    chk("post-reset fifo_ptr", int'(bus.fifo_ptr), 1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("post-reset empty", int'(bus.empty), 1);

    @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
